// File: rtl/irq_ctrl_if.sv
// Config bus and interrupt request/claim/complete signals between the core and
// irq_ctrl. Signal names keep the original _i/_o suffixes as seen from the
// controller.
//   slave  : irq_ctrl side (samples config/claim/complete, drives rdata/irq)
//   master : core/CSR side
interface irq_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int DW      = 32
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic            cfg_we_i;
  logic [1:0]      cfg_addr_i;
  logic [DW-1:0]   cfg_wdata_i;
  logic [DW-1:0]   cfg_rdata_o;
  logic            irq_o;
  logic [ID_W-1:0] irq_id_o;
  logic            claim_i;
  logic            complete_i;
  logic [ID_W-1:0] complete_id_i;

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i, claim_i, complete_i, complete_id_i,
    output cfg_rdata_o, irq_o, irq_id_o
  );

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i, claim_i, complete_i, complete_id_i,
    input  cfg_rdata_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller.
// Synchronises NUM_SRC raw sources, latches them as pending (edge or level
// mode), masks with a software enable, and presents the lowest-index eligible
// source as irq_o/irq_id_o. A claim moves the source from pending to
// in-service; a complete releases it.
// Ports:
//   clk_i  : core clock
//   rst_ni : asynchronous active-low reset
//   src_i  : raw asynchronous interrupt sources
//   bus    : config bus (we/addr/wdata/rdata) and irq/claim/complete handshake
// Config map: 0 ENABLE (RW), 1 MODE (RW, 1=edge), 2 PENDING (R, W1C),
//             3 INSERVICE (RO). Bits above NUM_SRC-1 read as 0.
module irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  irq_ctrl_if.slave          bus
);
  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ADDR_ENABLE    = 2'd0,
    ADDR_MODE      = 2'd1,
    ADDR_PENDING   = 2'd2,
    ADDR_INSERVICE = 2'd3
  } cfg_addr_e;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_insvc;

  logic [NUM_SRC-1:0] w_sync;
  logic [NUM_SRC-1:0] w_cfg_wdata;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_claim_oh;
  logic [NUM_SRC-1:0] w_cpl_oh;
  logic               w_irq;
  logic [ID_W-1:0]    w_irq_id;
  logic               w_claim_ok;
  logic               w_wr_en;
  logic               w_wr_mode;
  logic               w_wr_pend;
  logic [DW-1:0]      w_rdata;
  logic               w_unused_wdata;

  assign w_cfg_wdata    = bus.cfg_wdata_i[NUM_SRC-1:0];
  // Upper data bits have no storage behind them.
  assign w_unused_wdata = ^bus.cfg_wdata_i;

  assign w_wr_en   = bus.cfg_we_i && (cfg_addr_e'(bus.cfg_addr_i) == ADDR_ENABLE);
  assign w_wr_mode = bus.cfg_we_i && (cfg_addr_e'(bus.cfg_addr_i) == ADDR_MODE);
  assign w_wr_pend = bus.cfg_we_i && (cfg_addr_e'(bus.cfg_addr_i) == ADDR_PENDING);

  // Source synchroniser plus one extra sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], src_i};
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  assign w_elig = r_pending & r_enable & ~r_insvc;
  assign w_irq  = |w_elig;

  // Scan from the top down so the lowest eligible index is the last to land.
  always_comb begin
    w_irq_id = '0;
    for (int unsigned n = NUM_SRC; n > 0; n--) begin
      if (w_elig[n-1]) w_irq_id = ID_W'(n - 1);
    end
  end

  assign w_claim_ok = bus.claim_i && w_irq;

  // IDs at or above NUM_SRC match no channel, so such completes are dropped.
  always_comb begin
    w_claim_oh = '0;
    w_cpl_oh   = '0;
    for (int unsigned n = 0; n < NUM_SRC; n++) begin
      w_claim_oh[n] = w_claim_ok && (w_irq_id == ID_W'(n));
      w_cpl_oh[n]   = bus.complete_i && (bus.complete_id_i == ID_W'(n));
    end
  end

  assign w_set = (r_mode & w_sync & ~r_prev) | (~r_mode & w_sync & ~r_insvc);
  assign w_clr = w_claim_oh | (w_wr_pend ? w_cfg_wdata : '0);

  // Set is ORed in after clear so a coincident event is never lost; claim is
  // ORed in after complete so a same-ID claim keeps the channel in service.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enable  <= '0;
      r_mode    <= '0;
      r_pending <= '0;
      r_insvc   <= '0;
    end else begin
      if (w_wr_en)   r_enable <= w_cfg_wdata;
      if (w_wr_mode) r_mode   <= w_cfg_wdata;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_insvc   <= (r_insvc & ~w_cpl_oh) | w_claim_oh;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (cfg_addr_e'(bus.cfg_addr_i))
      ADDR_ENABLE:    w_rdata[NUM_SRC-1:0] = r_enable;
      ADDR_MODE:      w_rdata[NUM_SRC-1:0] = r_mode;
      ADDR_PENDING:   w_rdata[NUM_SRC-1:0] = r_pending;
      ADDR_INSERVICE: w_rdata[NUM_SRC-1:0] = r_insvc;
      default:        w_rdata = '0;
    endcase
  end

  assign bus.cfg_rdata_o = w_rdata;
  assign bus.irq_o       = w_irq;
  assign bus.irq_id_o    = w_irq_id;
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected outputs, a monitor
// pops and compares on each falling clock edge.
module tb_irq_ctrl;
  localparam int NUM_SRC = 8;
  localparam int DW      = 32;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] src = '0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(NUM_SRC), .DW(DW)) bus ();

  irq_ctrl #(.NUM_SRC(NUM_SRC), .DW(DW), .SYNC_STAGES(SYNC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .src_i  (src),
    .bus    (bus)
  );

  typedef struct {
    bit        irq;
    bit [2:0]  id;
    bit [31:0] rd;
    string     tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------- reference model ----------------
  bit [7:0] m_en, m_mode, m_pend, m_ins;
  bit [7:0] m_dly [0:SYNC];   // m_dly[SYNC-1] = synchronised, m_dly[SYNC] = previous

  function automatic int m_winner();
    for (int n = 0; n < NUM_SRC; n++)
      if (m_pend[n] && m_en[n] && !m_ins[n]) return n;
    return -1;
  endfunction

  function automatic bit [31:0] m_read(bit [1:0] a);
    bit [31:0] r;
    r = '0;
    case (a)
      2'd0: r[7:0] = m_en;
      2'd1: r[7:0] = m_mode;
      2'd2: r[7:0] = m_pend;
      default: r[7:0] = m_ins;
    endcase
    return r;
  endfunction

  function automatic void m_step();
    int       w;
    bit [7:0] sy, pv, np, ni;
    bit       ev, claimed, w1c, done;
    w  = m_winner();
    sy = m_dly[SYNC-1];
    pv = m_dly[SYNC];
    np = m_pend;
    ni = m_ins;
    for (int n = 0; n < NUM_SRC; n++) begin
      ev      = m_mode[n] ? (sy[n] && !pv[n]) : (sy[n] && !m_ins[n]);
      claimed = bus.claim_i && (w == n);
      w1c     = bus.cfg_we_i && (bus.cfg_addr_i == 2'd2) && bus.cfg_wdata_i[n];
      done    = bus.complete_i && (int'(bus.complete_id_i) == n);
      if (ev) np[n] = 1'b1;
      else if (claimed || w1c) np[n] = 1'b0;
      if (claimed) ni[n] = 1'b1;
      else if (done) ni[n] = 1'b0;
    end
    if (bus.cfg_we_i && bus.cfg_addr_i == 2'd0) m_en   = bus.cfg_wdata_i[7:0];
    if (bus.cfg_we_i && bus.cfg_addr_i == 2'd1) m_mode = bus.cfg_wdata_i[7:0];
    m_pend = np;
    m_ins  = ni;
    for (int k = SYNC; k > 0; k--) m_dly[k] = m_dly[k-1];
    m_dly[0] = src;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_ins = '0;
      for (int k = 0; k <= SYNC; k++) m_dly[k] = '0;
    end else begin
      m_step();
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.tag, "/irq"}, 32'(bus.irq_o), 32'(e.irq));
        chk({e.tag, "/id"},  32'(bus.irq_id_o), 32'(e.id));
        chk({e.tag, "/rd"},  bus.cfg_rdata_o, e.rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic advance();
    @(posedge clk);
    #2;
    bus.cfg_we_i   = 1'b0;
    bus.claim_i    = 1'b0;
    bus.complete_i = 1'b0;
  endtask

  task automatic cycle(string tag);
    exp_t e;
    int   w;
    w     = m_winner();
    e.irq = (w >= 0);
    e.id  = (w >= 0) ? 3'(w) : 3'd0;
    e.rd  = m_read(bus.cfg_addr_i);
    e.tag = tag;
    sb_q.push_back(e);
    advance();
  endtask

  task automatic cycle_c(string tag, bit irq, bit [2:0] id, bit [31:0] rd);
    exp_t e;
    e.irq = irq;
    e.id  = id;
    e.rd  = rd;
    e.tag = tag;
    sb_q.push_back(e);
    advance();
  endtask

  task automatic wr(bit [1:0] a, bit [31:0] d, string tag);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = a;
    bus.cfg_wdata_i = d;
    cycle(tag);
  endtask

  task automatic do_reset();
    src    = '0;
    rst_ni = 1'b0;
    #1;
    cycle("rst");
    rst_ni = 1'b1;
    cycle("rst_rel");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_wdata_i = 0;
    bus.claim_i = 0; bus.complete_i = 0; bus.complete_id_i = 0;
    repeat (3) @(posedge clk);
    #2;
    for (int a = 0; a < 4; a++) begin
      bus.cfg_addr_i = 2'(a);
      cycle_c("por", 1'b0, 3'd0, 32'h0);
    end
    rst_ni = 1'b1;
    cycle_c("por_rel", 1'b0, 3'd0, 32'h0);

    // Edge on ch0: irq three cycles after the source is driven
    wr(2'd0, 32'h01, "s1_en");
    wr(2'd1, 32'h01, "s1_mode");
    bus.cfg_addr_i = 2'd2;
    src = 8'h01; cycle_c("s1_a", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s1_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s1_c", 1'b0, 3'd0, 32'h0);
    cycle_c("s1_lat", 1'b1, 3'd0, 32'h01);
    cycle("s1_hold");

    // Priority and nested claims: ch2 then ch5
    do_reset();
    wr(2'd0, 32'hFF, "s2_en");
    wr(2'd1, 32'hFF, "s2_mode");
    bus.cfg_addr_i = 2'd3;
    src = 8'h24; cycle_c("s2_a", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s2_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s2_c", 1'b0, 3'd0, 32'h0);
    bus.claim_i = 1'b1; cycle_c("s2_id2", 1'b1, 3'd2, 32'h0);
    bus.claim_i = 1'b1; cycle_c("s2_id5", 1'b1, 3'd5, 32'h04);
    cycle_c("s2_none", 1'b0, 3'd0, 32'h24);

    // Level mode ch3 held high across claim/complete
    do_reset();
    wr(2'd0, 32'h08, "s3_en");
    wr(2'd1, 32'h00, "s3_mode");
    bus.cfg_addr_i = 2'd2;
    src = 8'h08; cycle_c("s3_a", 1'b0, 3'd0, 32'h0);
    cycle_c("s3_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s3_c", 1'b0, 3'd0, 32'h0);
    bus.claim_i = 1'b1; cycle_c("s3_irq", 1'b1, 3'd3, 32'h08);
    cycle_c("s3_insvc", 1'b0, 3'd0, 32'h08);
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd3;
    cycle_c("s3_cpl", 1'b0, 3'd0, 32'h08);
    cycle_c("s3_again", 1'b1, 3'd3, 32'h08);
    src = 8'h00; cycle("s3_end");

    // Edge on ch1 while ch1 is in service
    do_reset();
    wr(2'd0, 32'h02, "s4_en");
    wr(2'd1, 32'h02, "s4_mode");
    bus.cfg_addr_i = 2'd2;
    src = 8'h02; cycle_c("s4_a", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s4_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s4_c", 1'b0, 3'd0, 32'h0);
    bus.claim_i = 1'b1; cycle_c("s4_irq", 1'b1, 3'd1, 32'h02);
    src = 8'h02; cycle_c("s4_e", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s4_f", 1'b0, 3'd0, 32'h0);
    cycle_c("s4_g", 1'b0, 3'd0, 32'h0);
    cycle_c("s4_pend", 1'b0, 3'd0, 32'h02);
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd1;
    cycle_c("s4_cpl", 1'b0, 3'd0, 32'h02);
    cycle_c("s4_reirq", 1'b1, 3'd1, 32'h02);

    // Disabled ch4, W1C, and W1C racing a new edge
    do_reset();
    wr(2'd0, 32'h00, "s5_en");
    wr(2'd1, 32'h10, "s5_mode");
    bus.cfg_addr_i = 2'd2;
    src = 8'h10; cycle_c("s5_a", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s5_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s5_c", 1'b0, 3'd0, 32'h0);
    cycle_c("s5_pend", 1'b0, 3'd0, 32'h10);
    bus.cfg_we_i = 1'b1; bus.cfg_wdata_i = 32'h10;
    cycle_c("s5_w1c", 1'b0, 3'd0, 32'h10);
    cycle_c("s5_clr", 1'b0, 3'd0, 32'h0);
    src = 8'h10; cycle_c("s5_g", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s5_h", 1'b0, 3'd0, 32'h0);
    bus.cfg_we_i = 1'b1; bus.cfg_wdata_i = 32'h10;
    cycle_c("s5_race", 1'b0, 3'd0, 32'h0);
    cycle_c("s5_setwins", 1'b0, 3'd0, 32'h10);

    // Asynchronous reset with ch0 in service and ch6 pending
    do_reset();
    wr(2'd0, 32'h01, "s6_en");
    wr(2'd1, 32'h41, "s6_mode");
    bus.cfg_addr_i = 2'd2;
    src = 8'h41; cycle_c("s6_a", 1'b0, 3'd0, 32'h0);
    src = 8'h00; cycle_c("s6_b", 1'b0, 3'd0, 32'h0);
    cycle_c("s6_c", 1'b0, 3'd0, 32'h0);
    bus.claim_i = 1'b1; cycle_c("s6_irq", 1'b1, 3'd0, 32'h41);
    cycle_c("s6_insvc", 1'b0, 3'd0, 32'h40);
    #1;
    rst_ni = 1'b0;
    #1;
    cycle_c("s6_rst_pend", 1'b0, 3'd0, 32'h0);
    bus.cfg_addr_i = 2'd3;
    cycle_c("s6_rst_ins", 1'b0, 3'd0, 32'h0);
    rst_ni = 1'b1;
    bus.cfg_addr_i = 2'd2;
    bus.claim_i = 1'b1;
    cycle_c("s6_rel_pend", 1'b0, 3'd0, 32'h0);
    bus.cfg_addr_i = 2'd3;
    cycle_c("s6_noclaim_ins", 1'b0, 3'd0, 32'h0);
    bus.cfg_addr_i = 2'd2;
    cycle_c("s6_noclaim_pend", 1'b0, 3'd0, 32'h0);

    // Randomised traffic against the model
    do_reset();
    wr(2'd0, 32'hFF, "rnd_en");
    wr(2'd1, $urandom, "rnd_mode");
    for (int i = 0; i < 400; i++) begin
      src = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 99) < 12) begin
        bus.cfg_we_i    = 1'b1;
        bus.cfg_wdata_i = $urandom;
      end
      bus.cfg_addr_i    = 2'($urandom_range(0, 3));
      bus.claim_i       = 1'($urandom_range(0, 1));
      bus.complete_i    = ($urandom_range(0, 2) == 0);
      bus.complete_id_i = 3'($urandom_range(0, 7));
      cycle("rnd");
    end
    src = '0;
    cycle("rnd_tail");

    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d want=0 entries left", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
